// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch vectors, MIPS opcode/funct codes, fetch FSM encoding.
package cpu_pkg;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] IRQ_VEC  = 32'h8000_0004;
  localparam logic [31:0] EXC_VEC  = 32'h8000_0008;

  localparam logic [5:0] OP_SPECIAL = 6'd0;
  localparam logic [5:0] OP_REGIMM  = 6'd1;
  localparam logic [5:0] OP_J       = 6'd2;
  localparam logic [5:0] OP_JAL     = 6'd3;
  localparam logic [5:0] OP_BEQ     = 6'd4;
  localparam logic [5:0] OP_BNE     = 6'd5;
  localparam logic [5:0] OP_BLEZ    = 6'd6;
  localparam logic [5:0] OP_BGTZ    = 6'd7;

  localparam logic [5:0] FN_JR   = 6'd8;
  localparam logic [5:0] FN_JALR = 6'd9;

  typedef enum logic [0:0] {
    FS_RUN  = 1'b0,
    FS_HOLD = 1'b1
  } fetch_state_e;

  // Sequential PC step: 31-bit add, mode bit passes through untouched.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return {pc[31], pc[30:0] + 31'd4};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: ROM port, decode-side controls and the IF/ID / $k0 outputs.
interface fetch_stage_if;
  import cpu_pkg::*;

  logic [30:0]  rom_addr;
  logic [31:0]  rom_data;
  logic         stall;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  logic         exc;
  logic         irq;
  logic         id_valid;
  logic [31:0]  id_instr;
  logic [31:0]  id_pc;
  logic [31:0]  id_pc4;
  logic         epc_we;
  logic [31:0]  epc;
  logic         kernel;
  fetch_state_e fsm_state;

  modport master (
    output rom_addr,
    input  rom_data,
    input  stall,
    input  redirect_valid,
    input  redirect_pc,
    input  exc,
    input  irq,
    output id_valid,
    output id_instr,
    output id_pc,
    output id_pc4,
    output epc_we,
    output epc,
    output kernel,
    output fsm_state
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    output stall,
    output redirect_valid,
    output redirect_pc,
    output exc,
    output irq,
    input  id_valid,
    input  id_instr,
    input  id_pc,
    input  id_pc4,
    input  epc_we,
    input  epc,
    input  kernel,
    input  fsm_state
  );

endinterface

// File: rtl/fetch_stage_ctrl_predecode.sv
// Combinational control-transfer detector (branches, j/jal, jr/jalr); shared with decode.
module ctrl_predecode
  import cpu_pkg::*;
(
  input  logic [31:0] instr,
  output logic        is_ctrl
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       instr_unused;

  assign opcode       = instr[31:26];
  assign funct        = instr[5:0];
  assign instr_unused = ^instr[25:6];

  always_comb begin
    is_ctrl = 1'b0;
    case (opcode)
      OP_SPECIAL: is_ctrl = (funct == FN_JR) || (funct == FN_JALR);
      OP_REGIMM, OP_J, OP_JAL, OP_BEQ,
      OP_BNE, OP_BLEZ, OP_BGTZ: is_ctrl = 1'b1;
      default: is_ctrl = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC, IF/ID register, redirects, exception and interrupt vectoring.
// Interrupt entry is built only when FETCH_IRQ_EN is defined.
module fetch_stage
  import cpu_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  fetch_stage_if.master bus
);

  logic [31:0]  pc_q,       pc_d;
  logic         id_valid_q, id_valid_d;
  logic [31:0]  id_instr_q, id_instr_d;
  logic [31:0]  id_pc_q,    id_pc_d;
  logic [31:0]  id_pc4_q,   id_pc4_d;
  logic [31:0]  epc_q,      epc_d;
  logic         epc_we_q,   epc_we_d;
  fetch_state_e state_q,    state_d;

  logic         is_ctrl;
  logic         ctrl_in_ifid;
  logic         irq_pending;
  logic         irq_accept;
  logic [31:0]  redirect_target;
  logic [31:0]  pc_next_seq;

  ctrl_predecode u_predecode (
    .instr   (id_instr_q),
    .is_ctrl (is_ctrl)
  );

  assign ctrl_in_ifid = id_valid_q & is_ctrl;
  assign pc_next_seq  = pc_inc(pc_q);

`ifdef FETCH_IRQ_EN
  assign irq_pending = bus.irq & ~pc_q[31];
  assign irq_accept  = irq_pending & ~bus.stall & ~bus.redirect_valid
                     & ~bus.exc & ~ctrl_in_ifid;
`else
  logic irq_unused;
  assign irq_unused  = bus.irq ^ ctrl_in_ifid;
  assign irq_pending = 1'b0;
  assign irq_accept  = 1'b0;
`endif

  // User code cannot raise the mode bit through a jump target.
  always_comb begin
    redirect_target = {bus.redirect_pc[31:2], 2'b00};
    if (!pc_q[31]) begin
      redirect_target[31] = 1'b0;
    end
  end

  always_comb begin
    pc_d       = pc_q;
    id_valid_d = id_valid_q;
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;
    id_pc4_d   = id_pc4_q;
    epc_d      = epc_q;
    epc_we_d   = 1'b0;
    state_d    = state_q;

    if (bus.exc) begin
      pc_d       = EXC_VEC;
      epc_d      = id_pc_q;
      epc_we_d   = 1'b1;
      id_valid_d = 1'b0;
      id_instr_d = '0;
      state_d    = FS_RUN;
    end else if (bus.redirect_valid) begin
      pc_d       = redirect_target;
      id_valid_d = 1'b0;
      id_instr_d = '0;
      state_d    = irq_pending ? FS_HOLD : FS_RUN;
    end else if (irq_accept) begin
      // Only the fetched word is dropped; the IF/ID occupant proceeds to decode.
      pc_d       = IRQ_VEC;
      epc_d      = pc_q;
      epc_we_d   = 1'b1;
      id_valid_d = 1'b0;
      state_d    = FS_RUN;
    end else if (!bus.stall) begin
      pc_d       = pc_next_seq;
      id_valid_d = 1'b1;
      id_instr_d = bus.rom_data;
      id_pc_d    = pc_q;
      id_pc4_d   = pc_next_seq;
      state_d    = irq_pending ? FS_HOLD : FS_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_q       <= RESET_PC;
      id_valid_q <= 1'b0;
      id_instr_q <= '0;
      id_pc_q    <= '0;
      id_pc4_q   <= '0;
      epc_q      <= '0;
      epc_we_q   <= 1'b0;
      state_q    <= FS_RUN;
    end else begin
      pc_q       <= pc_d;
      id_valid_q <= id_valid_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
      id_pc4_q   <= id_pc4_d;
      epc_q      <= epc_d;
      epc_we_q   <= epc_we_d;
      state_q    <= state_d;
    end
  end

  assign bus.rom_addr  = pc_q[30:0];
  assign bus.kernel    = pc_q[31];
  assign bus.id_valid  = id_valid_q;
  assign bus.id_instr  = id_instr_q;
  assign bus.id_pc     = id_pc_q;
  assign bus.id_pc4    = id_pc4_q;
  assign bus.epc       = epc_q;
  assign bus.epc_we    = epc_we_q;
  assign bus.fsm_state = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; expectations follow FETCH_IRQ_EN as compiled.
module tb_fetch_stage;
  import cpu_pkg::*;

`ifdef FETCH_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic clk;
  logic reset_n;
  logic [31:0] rom [0:255];

  int tests_run;
  int tests_failed;

  fetch_stage_if fif ();

  fetch_stage dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (fif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb fif.rom_data = rom[fif.rom_addr[9:2]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic redirect_to(input logic [31:0] target);
    fif.redirect_valid = 1'b1;
    fif.redirect_pc    = target;
    tick();
    fif.redirect_valid = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    for (int i = 0; i < 256; i++) rom[i] = 32'h0000_0000;
    rom[0]  = 32'h0800_0003;  // j
    rom[15] = 32'h0085_1024;  // and at 0x3C
    rom[20] = 32'h1120_fffd;  // beq at 0x50

    reset_n            = 1'b0;
    fif.stall          = 1'b0;
    fif.redirect_valid = 1'b0;
    fif.redirect_pc    = '0;
    fif.exc            = 1'b0;
    fif.irq            = 1'b0;
    repeat (3) tick();

    check("rst_rom_addr", 32'(fif.rom_addr), 32'h0);
    check("rst_id_valid", 32'(fif.id_valid), 32'h0);
    check("rst_id_instr", fif.id_instr, 32'h0);
    check("rst_id_pc",    fif.id_pc, 32'h0);
    check("rst_epc",      fif.epc, 32'h0);
    check("rst_epc_we",   32'(fif.epc_we), 32'h0);
    check("rst_kernel",   32'(fif.kernel), 32'h1);

    reset_n = 1'b1;
    tick();
    check("seq_id_instr", fif.id_instr, 32'h0800_0003);
    check("seq_id_pc",    fif.id_pc, 32'h8000_0000);
    check("seq_id_pc4",   fif.id_pc4, 32'h8000_0004);
    check("seq_id_valid", 32'(fif.id_valid), 32'h1);
    check("seq_rom_addr", 32'(fif.rom_addr), 32'h4);
    tick();
    check("seq_rom_addr2", 32'(fif.rom_addr), 32'h8);

    fif.stall = 1'b1;
    repeat (2) tick();
    check("stall_rom_addr", 32'(fif.rom_addr), 32'h8);
    check("stall_id_pc",    fif.id_pc, 32'h8000_0004);
    check("stall_id_valid", 32'(fif.id_valid), 32'h1);
    redirect_to(32'h0000_000C);
    check("stredir_rom_addr", 32'(fif.rom_addr), 32'hC);
    check("stredir_id_valid", 32'(fif.id_valid), 32'h0);
    check("stredir_kernel",   32'(fif.kernel), 32'h0);
    fif.stall = 1'b0;
    tick();
    check("bubble_id_pc",    fif.id_pc, 32'h0000_000C);
    check("bubble_id_valid", 32'(fif.id_valid), 32'h1);

    // Interrupt entry with a plain ALU op in IF/ID.
    redirect_to(32'h0000_003C);
    tick();
    check("pre_irq_rom_addr", 32'(fif.rom_addr), 32'h40);
    fif.irq = 1'b1;
    tick();
    check("irq_pc",     {fif.kernel, fif.rom_addr}, IRQ_EN ? 32'h8000_0004 : 32'h0000_0044);
    check("irq_epc",    fif.epc, IRQ_EN ? 32'h0000_0040 : 32'h0);
    check("irq_epc_we", 32'(fif.epc_we), IRQ_EN ? 32'h1 : 32'h0);
    check("irq_id_valid", 32'(fif.id_valid), IRQ_EN ? 32'h0 : 32'h1);
    tick();
    check("irq_k_pc",     {fif.kernel, fif.rom_addr}, IRQ_EN ? 32'h8000_0008 : 32'h0000_0048);
    check("irq_k_epc_we", 32'(fif.epc_we), 32'h0);
    check("irq_vec_id_pc", fif.id_pc, IRQ_EN ? 32'h8000_0004 : 32'h0000_0044);
    check("irq_epc_hold", fif.epc, IRQ_EN ? 32'h0000_0040 : 32'h0);
    fif.irq = 1'b0;

    // Untaken branch in IF/ID defers entry by one cycle.
    redirect_to(32'h0000_0050);
    tick();
    fif.irq = 1'b1;
    tick();
    check("blk_rom_addr", 32'(fif.rom_addr), 32'h58);
    check("blk_state",    32'(fif.fsm_state), IRQ_EN ? 32'(FS_HOLD) : 32'(FS_RUN));
    check("blk_epc_we",   32'(fif.epc_we), 32'h0);
    tick();
    check("blk_acc_pc",  {fif.kernel, fif.rom_addr}, IRQ_EN ? 32'h8000_0004 : 32'h0000_005C);
    check("blk_acc_epc", fif.epc, IRQ_EN ? 32'h0000_0058 : 32'h0);
    check("blk_acc_state", 32'(fif.fsm_state), 32'(FS_RUN));
    fif.irq = 1'b0;

    // Taken branch: entry follows the redirect, epc is the target.
    redirect_to(32'h0000_0050);
    tick();
    fif.irq = 1'b1;
    redirect_to(32'h0000_0060);
    check("tkn_rom_addr", 32'(fif.rom_addr), 32'h60);
    check("tkn_state",    32'(fif.fsm_state), IRQ_EN ? 32'(FS_HOLD) : 32'(FS_RUN));
    check("tkn_epc_we",   32'(fif.epc_we), 32'h0);
    tick();
    check("tkn_acc_pc",     {fif.kernel, fif.rom_addr}, IRQ_EN ? 32'h8000_0004 : 32'h0000_0064);
    check("tkn_acc_epc",    fif.epc, IRQ_EN ? 32'h0000_0060 : 32'h0);
    check("tkn_acc_epc_we", 32'(fif.epc_we), IRQ_EN ? 32'h1 : 32'h0);
    fif.irq = 1'b0;

    // Exception overrides stall; irq is ignored throughout.
    redirect_to(32'h0000_0094);
    tick();
    check("pre_exc_id_pc", fif.id_pc, 32'h0000_0094);
    fif.exc   = 1'b1;
    fif.stall = 1'b1;
    fif.irq   = 1'b1;
    tick();
    check("exc_pc",       {fif.kernel, fif.rom_addr}, 32'h8000_0008);
    check("exc_epc",      fif.epc, 32'h0000_0094);
    check("exc_epc_we",   32'(fif.epc_we), 32'h1);
    check("exc_id_valid", 32'(fif.id_valid), 32'h0);
    check("exc_id_instr", fif.id_instr, 32'h0);
    fif.exc   = 1'b0;
    fif.stall = 1'b0;
    tick();
    check("exc_k_pc",     {fif.kernel, fif.rom_addr}, 32'h8000_000C);
    check("exc_epc_hold", fif.epc, 32'h0000_0094);
    check("exc_epc_we0",  32'(fif.epc_we), 32'h0);
    fif.irq = 1'b0;

    // Kernel jr $k0 drops to user; user targets are clamped and word-aligned.
    redirect_to(32'h0000_0088);
    check("jr_k0_rom_addr", 32'(fif.rom_addr), 32'h88);
    check("jr_k0_kernel",   32'(fif.kernel), 32'h0);
    redirect_to(32'h8000_0020);
    check("clamp_rom_addr", 32'(fif.rom_addr), 32'h20);
    check("clamp_kernel",   32'(fif.kernel), 32'h0);
    redirect_to(32'h0000_0027);
    check("align_rom_addr", 32'(fif.rom_addr), 32'h24);

    // 31-bit wrap without carrying into the mode bit.
    redirect_to(32'h7FFF_FFFC);
    tick();
    check("wrap_pc",     {fif.kernel, fif.rom_addr}, 32'h0000_0000);
    check("wrap_id_pc",  fif.id_pc, 32'h7FFF_FFFC);
    check("wrap_id_pc4", fif.id_pc4, 32'h0000_0000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
